// File: rtl/data_bus_if.sv
// CPU-side memory bus between the EX/MEM register and the MEM-stage data bus.
// The master drives the access; the slave returns combinational load data.
interface data_bus_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output mem_read,
    output mem_write,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  address,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/data_bus.sv
// MEM-stage data bus: word-addressed data RAM plus memory-mapped timer,
// LEDs, seven-segment digits and a free-running systick counter.
module data_bus #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  data_bus_if.slave   bus,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  localparam int AW = $clog2(RAM_WORDS);

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [29:0] WA_TH      = 30'h1000_0000;
  localparam logic [29:0] WA_TL      = 30'h1000_0001;
  localparam logic [29:0] WA_TCON    = 30'h1000_0002;
  localparam logic [29:0] WA_LEDS    = 30'h1000_0003;
  localparam logic [29:0] WA_DIGITS  = 30'h1000_0004;
  localparam logic [29:0] WA_SYSTICK = 30'h1000_0005;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LEDS,
    SEL_DIGITS,
    SEL_SYSTICK
  } sel_t;

  sel_t          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [7:0]  leds_q;
  logic [11:0] digits_q;

  logic [31:0] th_next;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic [31:0] rdata;

  logic unused_addr_bits;

  // Word access only: the byte offset never participates in decode.
  assign unused_addr_bits = ^bus.address[1:0];
  assign ram_idx          = bus.address[AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (bus.address[31:AW+2] == '0) begin
      sel = SEL_RAM;
    end else begin
      case (bus.address[31:2])
        WA_TH:      sel = SEL_TH;
        WA_TL:      sel = SEL_TL;
        WA_TCON:    sel = SEL_TCON;
        WA_LEDS:    sel = SEL_LEDS;
        WA_DIGITS:  sel = SEL_DIGITS;
        WA_SYSTICK: sel = SEL_SYSTICK;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  // Timer step first, then a CPU store overrides only the register it targets.
  always_comb begin
    th_next   = th;
    tl_next   = tl;
    tcon_next = tcon;
    if (tcon[0]) begin
      if (tl == 32'hFFFF_FFFF) begin
        tl_next = th;
        if (tcon[1]) begin
          tcon_next[2] = 1'b1;
        end
      end else begin
        tl_next = tl + 32'd1;
      end
    end
    if (bus.mem_write) begin
      case (sel)
        SEL_TH:   th_next   = bus.write_data;
        SEL_TL:   tl_next   = bus.write_data;
        SEL_TCON: tcon_next = bus.write_data[2:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th       <= '0;
      tl       <= '0;
      tcon     <= '0;
      systick  <= '0;
      leds_q   <= '0;
      digits_q <= '0;
    end else begin
      th      <= th_next;
      tl      <= tl_next;
      tcon    <= tcon_next;
      systick <= systick + 32'd1;
      if (bus.mem_write && sel == SEL_LEDS) begin
        leds_q <= bus.write_data[7:0];
      end
      if (bus.mem_write && sel == SEL_DIGITS) begin
        digits_q <= bus.write_data[11:0];
      end
    end
  end

  // Reset clears every RAM word so loads after reset are deterministic.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_WORDS; i++) begin
        ram[i] <= '0;
      end
    end else if (bus.mem_write && sel == SEL_RAM) begin
      ram[ram_idx] <= bus.write_data;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.mem_read) begin
      case (sel)
        SEL_RAM:     rdata = ram[ram_idx];
        SEL_TH:      rdata = th;
        SEL_TL:      rdata = tl;
        SEL_TCON:    rdata = {29'd0, tcon};
        SEL_LEDS:    rdata = {24'd0, leds_q};
        SEL_DIGITS:  rdata = {20'd0, digits_q};
        SEL_SYSTICK: rdata = systick;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.read_data = rdata;
  assign irq           = tcon[2];
  assign leds          = leds_q;
  assign digits        = digits_q;

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed scenarios plus a randomized run
// compared against an abstract memory-map model kept in the bench.
module tb_data_bus;
  localparam int RAM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  data_bus_if bus ();

  data_bus #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq    (irq),
    .leds   (leds),
    .digits (digits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [RAM_WORDS];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_leds;
  logic [11:0] m_digits;

  function automatic void model_reset();
    for (int i = 0; i < RAM_WORDS; i++) m_ram[i] = '0;
    m_th = '0; m_tl = '0; m_tcon = '0; m_systick = '0;
    m_leds = '0; m_digits = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    if (!rd) return 32'd0;
    if (a < 32'(RAM_WORDS * 4)) return m_ram[a[9:2]];
    case ({a[31:2], 2'b00})
      32'h4000_0000: return m_th;
      32'h4000_0004: return m_tl;
      32'h4000_0008: return {29'd0, m_tcon};
      32'h4000_000C: return {24'd0, m_leds};
      32'h4000_0010: return {20'd0, m_digits};
      32'h4000_0014: return m_systick;
      default:       return 32'd0;
    endcase
  endfunction

  // One clock edge of the memory map: timer rules, then the store wins.
  function automatic void model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] nth, ntl;
    logic [2:0]  ntcon;
    nth = m_th; ntl = m_tl; ntcon = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        ntl = m_th;
        if (m_tcon[1]) ntcon[2] = 1'b1;
      end else begin
        ntl = m_tl + 32'd1;
      end
    end
    if (wr) begin
      if (a < 32'(RAM_WORDS * 4)) m_ram[a[9:2]] = d;
      else begin
        case ({a[31:2], 2'b00})
          32'h4000_0000: nth = d;
          32'h4000_0004: ntl = d;
          32'h4000_0008: ntcon = d[2:0];
          32'h4000_000C: m_leds = d[7:0];
          32'h4000_0010: m_digits = d[11:0];
          default: ;
        endcase
      end
    end
    m_th = nth; m_tl = ntl; m_tcon = ntcon;
    m_systick = m_systick + 32'd1;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got);
    bus.mem_read = rd; bus.mem_write = wr; bus.address = a; bus.write_data = d;
    @(negedge clk);
    got = bus.read_data;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(wr, a, d);
    #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    access(1'b0, 1'b1, a, d, dummy);
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] got);
    access(1'b1, 1'b0, a, 32'd0, got);
  endtask

  task automatic apply_reset();
    logic [31:0] dummy;
    reset = 1'b1;
    repeat (2) access(1'b0, 1'b0, 32'd0, 32'd0, dummy);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    logic [31:0] addrs [6];
    addrs = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0008,
              32'h4000_000C, 32'h4000_0010, 32'h0000_0010};
    apply_reset();
    store(32'h0000_0010, 32'h1234_5678);
    store(32'h4000_000C, 32'hFF);
    store(32'h4000_0010, 32'hABC);
    store(32'h4000_0000, 32'h55);
    store(32'h4000_0004, 32'hFFFF_FFFF);
    store(32'h4000_0008, 32'h3);
    store(32'h0000_0000, 32'h1);
    apply_reset();
    load(32'h4000_0014, got);
    checks++;
    if (got !== 32'd0) begin errors++; $display("[TB] FAIL reset_systick got %h expected %h", got, 32'd0); end
    for (int i = 0; i < 6; i++) begin
      load(addrs[i], got);
      checks++;
      if (got !== 32'd0) begin errors++; $display("[TB] FAIL reset_read[%0h] got %h expected %h", addrs[i], got, 32'd0); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b expected 0", irq); end
    checks++;
    if (leds !== 8'd0) begin errors++; $display("[TB] FAIL reset_leds got %h expected 00", leds); end
    checks++;
    if (digits !== 12'd0) begin errors++; $display("[TB] FAIL reset_digits got %h expected 000", digits); end
  endtask

  task automatic test_ram();
    logic [31:0] got;
    logic [31:0] dummy;
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load(32'h0000_0010, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_load got %h expected deadbeef", got); end
    load(32'h0000_0013, got);
    checks++;
    if (got !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_low_bits got %h expected deadbeef", got); end
    load(32'h0000_0400, got);
    checks++;
    if (got !== 32'd0) begin errors++; $display("[TB] FAIL ram_unmapped got %h expected 0", got); end
    access(1'b0, 1'b0, 32'h0000_0010, 32'd0, dummy);
    checks++;
    if (dummy !== 32'd0) begin errors++; $display("[TB] FAIL ram_no_read got %h expected 0", dummy); end
  endtask

  task automatic test_timer_overflow();
    logic [31:0] got;
    logic [31:0] exp_tl [4];
    logic        exp_irq [4];
    exp_tl  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE};
    exp_irq = '{1'b0, 1'b1, 1'b1, 1'b1};
    store(32'h4000_0000, 32'hFFFF_FFFD);
    store(32'h4000_0004, 32'hFFFF_FFFE);
    store(32'h4000_0008, 32'h3);
    for (int i = 0; i < 4; i++) begin
      load(32'h4000_0004, got);
      checks++;
      if (got !== exp_tl[i]) begin errors++; $display("[TB] FAIL overflow_tl[%0d] got %h expected %h", i, got, exp_tl[i]); end
      checks++;
      if (irq !== exp_irq[i]) begin errors++; $display("[TB] FAIL overflow_irq[%0d] got %b expected %b", i, irq, exp_irq[i]); end
    end
    store(32'h4000_0008, 32'h3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear got %b expected 0", irq); end
    store(32'h4000_0008, 32'h0);
  endtask

  task automatic test_collision();
    logic [31:0] got;
    store(32'h4000_0000, 32'h0000_1234);
    store(32'h4000_0004, 32'hFFFF_FFFF);
    store(32'h4000_0008, 32'h3);
    store(32'h4000_0004, 32'h5);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL collision_irq got %b expected 1", irq); end
    load(32'h4000_0004, got);
    checks++;
    if (got !== 32'h5) begin errors++; $display("[TB] FAIL collision_tl got %h expected 5", got); end
    load(32'h4000_0000, got);
    checks++;
    if (got !== 32'h1234) begin errors++; $display("[TB] FAIL collision_th got %h expected 1234", got); end
    store(32'h4000_0008, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL collision_clear got %b expected 0", irq); end
  endtask

  task automatic test_peripherals();
    logic [31:0] got, s1, s2, exp;
    store(32'h4000_000C, 32'h1A5);
    checks++;
    if (leds !== 8'hA5) begin errors++; $display("[TB] FAIL leds got %h expected a5", leds); end
    load(32'h4000_000C, got);
    checks++;
    if (got !== 32'hA5) begin errors++; $display("[TB] FAIL leds_read got %h expected a5", got); end
    store(32'h4000_0010, 32'hFFFF_F123);
    checks++;
    if (digits !== 12'h123) begin errors++; $display("[TB] FAIL digits got %h expected 123", digits); end
    load(32'h4000_0010, got);
    checks++;
    if (got !== 32'h123) begin errors++; $display("[TB] FAIL digits_read got %h expected 123", got); end
    store(32'h4000_0014, 32'h0);
    exp = model_read(1'b1, 32'h4000_0014);
    load(32'h4000_0014, s1);
    checks++;
    if (s1 !== exp) begin errors++; $display("[TB] FAIL systick_value got %h expected %h", s1, exp); end
    load(32'h4000_0014, s2);
    checks++;
    if (s2 !== s1 + 32'd1) begin errors++; $display("[TB] FAIL systick_step got %h expected %h", s2, s1 + 32'd1); end
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] got;
    store(32'h0, 32'd7);
    access(1'b1, 1'b1, 32'h0, 32'd9, got);
    checks++;
    if (got !== 32'd7) begin errors++; $display("[TB] FAIL rw_old got %h expected 7", got); end
    load(32'h0, got);
    checks++;
    if (got !== 32'd9) begin errors++; $display("[TB] FAIL rw_new got %h expected 9", got); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp, a, d;
    logic        rd, wr;
    int          kind;
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 4) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
      else if (kind == 4) a = 32'h0000_0400 + 32'($urandom_range(0, 4095));
      else a = 32'h4000_0000 + 32'($urandom_range(0, 7) * 4);
      d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      exp = model_read(rd, a);
      access(rd, wr, a, d, got);
      checks++;
      if (got !== exp) begin errors++; $display("[TB] FAIL rand_read[%0d] addr %h got %h expected %h", i, a, got, exp); end
      checks++;
      if (irq !== m_tcon[2]) begin errors++; $display("[TB] FAIL rand_irq[%0d] got %b expected %b", i, irq, m_tcon[2]); end
      checks++;
      if (leds !== m_leds) begin errors++; $display("[TB] FAIL rand_leds[%0d] got %h expected %h", i, leds, m_leds); end
      checks++;
      if (digits !== m_digits) begin errors++; $display("[TB] FAIL rand_digits[%0d] got %h expected %h", i, digits, m_digits); end
    end
  endtask

  initial begin
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    model_reset();
    test_reset();
    test_ram();
    test_timer_overflow();
    test_collision();
    test_peripherals();
    test_read_write_same_cycle();
    test_random();
    apply_reset();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
